// File: rtl/atmega_pcint.sv
// Pin-change input stage for one 8-bit ATmega port.
// Synchronises the pads into the clock domain and feeds the PIO pin-read input.
// Implements PCICR (PCIE), PCIFR (PCIF) and PCMSK on the data-space bus.
// Raises a level interrupt request to the core.
// Optional per-bit debounce filter: define ATMEGA_PCINT_DEBOUNCE_EN.
module atmega_pcint #(
  parameter int unsigned BUS_ADDR_DATA_LEN = 16,
  parameter int unsigned PCICR_ADDR        = 'h68,
  parameter int unsigned PCIFR_ADDR        = 'h3B,
  parameter int unsigned PCMSK_ADDR        = 'h6B,
  parameter int unsigned DEBOUNCE_CYCLES   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [7:0]                   bus_in,
  output logic [7:0]                   bus_out,
  input  logic [7:0]                   pad_in,
  output logic [7:0]                   pin_sync,
  output logic                         int_req,
  input  logic                         int_ack
);

  localparam int unsigned PW = 8;
  localparam int unsigned AW = BUS_ADDR_DATA_LEN;

  localparam logic [AW-1:0] PCICR_A = AW'(PCICR_ADDR);
  localparam logic [AW-1:0] PCIFR_A = AW'(PCIFR_ADDR);
  localparam logic [AW-1:0] PCMSK_A = AW'(PCMSK_ADDR);

  // The stability window must be at least one clock; nothing is built here
  // unless the parameter is out of range.
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_cycles_out_of_range
  end

  logic [PW-1:0] s1_q;
  logic [PW-1:0] s2_q;
  logic [PW-1:0] prev_q, prev_d;
  logic [PW-1:0] pcmsk_q, pcmsk_d;
  logic          pcie_q, pcie_d;
  logic          pcif_q, pcif_d;

  logic          sel_pcicr_c;
  logic          sel_pcifr_c;
  logic          sel_pcmsk_c;
  logic          chg_c;
  logic          pcif_clr_c;

  // Address decode shared by the write and read paths.
  always_comb begin
    sel_pcicr_c = (addr == PCICR_A);
    sel_pcifr_c = (addr == PCIFR_A);
    sel_pcmsk_c = (addr == PCMSK_A);
  end

  // Two-flop synchroniser on every pad bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pad_in;
      s2_q <= s1_q;
    end
  end

`ifdef ATMEGA_PCINT_DEBOUNCE_EN
  localparam int unsigned  CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [PW-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]            pin_q, pin_d;

  // A bit follows s2 only after s2 has disagreed with it for the full window;
  // any return to agreement restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    pin_d = pin_q;
    for (int i = 0; i < int'(PW); i++) begin
      if (s2_q[i] != pin_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          pin_d[i] = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Debounce counter and filtered pin state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      pin_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pin_q <= pin_d;
    end
  end

  assign pin_sync = pin_q;
`else
  assign pin_sync = s2_q;
`endif

  // Next-state for registers, change detector and flag.
  always_comb begin
    pcie_d     = pcie_q;
    pcmsk_d    = pcmsk_q;
    pcif_d     = pcif_q;
    prev_d     = pin_sync;
    // Registered mask: a PCMSK write only affects detection from the next cycle.
    chg_c      = |((pin_sync ^ prev_q) & pcmsk_q);
    pcif_clr_c = int_ack | (wr & sel_pcifr_c & bus_in[0]);

    if (wr && sel_pcicr_c) begin
      pcie_d = bus_in[0];
    end
    if (wr && sel_pcmsk_c) begin
      pcmsk_d = bus_in;
    end

    // Set wins over any clear arriving in the same cycle.
    if (pcif_clr_c) begin
      pcif_d = 1'b0;
    end
    if (chg_c) begin
      pcif_d = 1'b1;
    end
  end

  // Control registers, flag and previous-pin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= '0;
      pcmsk_q <= '0;
      pcie_q  <= 1'b0;
      pcif_q  <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pcmsk_q <= pcmsk_d;
      pcie_q  <= pcie_d;
      pcif_q  <= pcif_d;
    end
  end

  assign int_req = pcif_q & pcie_q;

  // Combinational read mux; quiet when not reading or in reset.
  always_comb begin
    bus_out = 8'h00;
    if (rd && !rst) begin
      if (sel_pcicr_c) begin
        bus_out = {7'b0, pcie_q};
      end else if (sel_pcifr_c) begin
        bus_out = {7'b0, pcif_q};
      end else if (sel_pcmsk_c) begin
        bus_out = pcmsk_q;
      end
    end
  end

endmodule
